// File: rtl/ext_bus_pkg.sv
// Shared encodings for the 6502 pin-bus bridge: phase values, request FSM
// states and the uio_oe patterns the core drives for writes and reads.
package ext_bus_pkg;

    localparam logic PH_LO = 1'b1;
    localparam logic PH_HI = 1'b0;

    localparam logic [7:0] DB_OE_WRITE = 8'hFF;
    localparam logic [7:0] DB_OE_READ  = 8'h00;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } req_state_t;

    // True when the core's data-pin direction disagrees with the captured rw.
    function automatic logic oe_mismatch(input logic rw, input logic [7:0] oe);
        return rw ? (oe != DB_OE_READ) : (oe != DB_OE_WRITE);
    endfunction

endpackage

// File: rtl/ext_bus_bridge_if.sv
// Flat memory request port: one request at a time, held until mem_ready.
// For reads, mem_rdata is valid in the same cycle as mem_ready.
interface ext_bus_bridge_if;
    import ext_bus_pkg::*;

    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ready;
    logic [7:0]  mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_ready,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready,
        output mem_rdata
    );

endinterface

// File: rtl/bus_phase_tracker.sv
// Tracks the LO/HI phase of the core's time-shared pin bus. The reset value
// must match the core's clock-enable reset value so both sides agree.
module bus_phase_tracker
    import ext_bus_pkg::*;
#(
    parameter logic PHASE_INIT = PH_LO
) (
    input  logic clk,
    input  logic rst_n,
    output logic phase
);

    // Phase alternates every clock, starting from PHASE_INIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= PHASE_INIT;
        end else begin
            phase <= ~phase;
        end
    end

endmodule

// File: rtl/ext_bus_bridge.sv
// Rebuilds each two-clock 6502 pin-bus cycle into one flat 16-bit memory
// request and returns registered read data to the core's data input.
module ext_bus_bridge
    import ext_bus_pkg::*;
#(
    parameter logic [7:0] IDLE_DATA  = 8'hEA,
    parameter logic       PHASE_INIT = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       cpu_ab_mux,
    input  logic [7:0]       cpu_db_mux,
    input  logic [7:0]       cpu_db_oe,
    output logic [7:0]       cpu_db_in,
    ext_bus_bridge_if.master mem,
    output logic             phase,
    output logic             overrun,
    output logic             protocol_err
);

    logic        phase_q;
    logic [7:0]  addr_lo;
    logic        rw_q;
    logic        hi_capture;

    req_state_t  state;
    req_state_t  state_next;
    logic        load_req;
    logic        complete;
    logic        drop;

    logic [15:0] addr_q;
    logic        we_q;
    logic [7:0]  wdata_q;
    logic [7:0]  db_in_q;

    bus_phase_tracker #(
        .PHASE_INIT(PHASE_INIT)
    ) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .phase (phase_q)
    );

    assign phase      = phase_q;
    assign hi_capture = (phase_q == PH_HI);

    // LO phase: latch the address low byte and the rw bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo <= '0;
            rw_q    <= 1'b1;
        end else if (phase_q == PH_LO) begin
            addr_lo <= cpu_ab_mux;
            rw_q    <= cpu_db_mux[0];
        end
    end

    // Request FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus load/complete/drop strobes for the datapath.
    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        complete   = 1'b0;
        drop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (hi_capture) begin
                    load_req   = 1'b1;
                    state_next = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem.mem_ready) begin
                    complete = 1'b1;
                    if (hi_capture) begin
                        load_req = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (hi_capture) begin
                    drop = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Request registers only change on a load, so they stay stable while mem_req is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
        end else if (load_req) begin
            addr_q <= {cpu_ab_mux, addr_lo};
            we_q   <= ~rw_q;
            if (!rw_q) begin
                wdata_q <= cpu_db_mux;
            end
        end
    end

    // Read data returns to the core only when a read is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_in_q <= IDLE_DATA;
        end else if (complete && !we_q) begin
            db_in_q <= mem.mem_rdata;
        end
    end

    // Sticky error flags; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun      <= 1'b0;
            protocol_err <= 1'b0;
        end else begin
            if (drop) begin
                overrun <= 1'b1;
            end
            if (hi_capture && oe_mismatch(rw_q, cpu_db_oe)) begin
                protocol_err <= 1'b1;
            end
        end
    end

    assign mem.mem_req   = (state == ST_REQ);
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign cpu_db_in     = db_in_q;

endmodule

// File: tb/tb_ext_bus_bridge.sv
// Directed bench for ext_bus_bridge: a continuous stream of core bus cycles
// with hand-computed expectations for reads, writes, stalls, overrun,
// protocol errors and asynchronous reset.
module tb_ext_bus_bridge;
    import ext_bus_pkg::*;

    logic       clk;
    logic       rst_n;
    logic [7:0] cpu_ab_mux;
    logic [7:0] cpu_db_mux;
    logic [7:0] cpu_db_oe;
    logic [7:0] cpu_db_in;
    logic       phase;
    logic       overrun;
    logic       protocol_err;

    int unsigned n_checks;
    int unsigned n_pass;

    ext_bus_bridge_if mem_if ();

    ext_bus_bridge #(
        .IDLE_DATA  (8'hEA),
        .PHASE_INIT (1'b1)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cpu_ab_mux   (cpu_ab_mux),
        .cpu_db_mux   (cpu_db_mux),
        .cpu_db_oe    (cpu_db_oe),
        .cpu_db_in    (cpu_db_in),
        .mem          (mem_if.master),
        .phase        (phase),
        .overrun      (overrun),
        .protocol_err (protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One LO-phase clock; returns #1 after the edge that ends it.
    task automatic lo(input logic [7:0] alo, input logic rw);
        cpu_ab_mux = alo;
        cpu_db_mux = {7'b0, rw};
        cpu_db_oe  = 8'h00;
        @(posedge clk);
        #1;
    endtask

    // One HI-phase clock; returns #1 after the edge that ends it.
    task automatic hi(input logic [7:0] ahi, input logic [7:0] wd, input logic [7:0] oe);
        cpu_ab_mux = ahi;
        cpu_db_mux = wd;
        cpu_db_oe  = oe;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks          = 0;
        n_pass            = 0;
        rst_n             = 1'b0;
        cpu_ab_mux        = 8'h00;
        cpu_db_mux        = 8'h01;
        cpu_db_oe         = 8'h00;
        mem_if.mem_ready  = 1'b1;
        mem_if.mem_rdata  = 8'h5A;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   {15'd0, mem_if.mem_req}, 16'h0000);
        check("rst_we",    {15'd0, mem_if.mem_we},  16'h0000);
        check("rst_addr",  mem_if.mem_addr,         16'h0000);
        check("rst_wdata", {8'd0, mem_if.mem_wdata}, 16'h0000);
        check("rst_dbin",  {8'd0, cpu_db_in},       16'h00EA);
        check("rst_phase", {15'd0, phase},          16'h0001);
        check("rst_ovr",   {15'd0, overrun},        16'h0000);
        check("rst_perr",  {15'd0, protocol_err},   16'h0000);

        // Read 16'h1234, zero-wait memory.
        @(negedge clk);
        rst_n = 1'b1;
        lo(8'h34, 1'b1);
        check("rd_hi_phase", {15'd0, phase}, 16'h0000);
        hi(8'h12, 8'h00, 8'h00);
        check("rd_req",   {15'd0, mem_if.mem_req}, 16'h0001);
        check("rd_addr",  mem_if.mem_addr,         16'h1234);
        check("rd_we",    {15'd0, mem_if.mem_we},  16'h0000);
        check("rd_phase", {15'd0, phase},          16'h0001);

        // Write 8'hC3 to 16'h00FF; its LO phase overlaps the read's acceptance.
        lo(8'hFF, 1'b0);
        check("rd_req_one", {15'd0, mem_if.mem_req}, 16'h0000);
        check("rd_dbin",    {8'd0, cpu_db_in},       16'h005A);
        mem_if.mem_rdata = 8'h77;
        hi(8'h00, 8'hC3, 8'hFF);
        check("wr_req",   {15'd0, mem_if.mem_req},   16'h0001);
        check("wr_we",    {15'd0, mem_if.mem_we},    16'h0001);
        check("wr_addr",  mem_if.mem_addr,           16'h00FF);
        check("wr_wdata", {8'd0, mem_if.mem_wdata},  16'h00C3);
        check("wr_perr",  {15'd0, protocol_err},     16'h0000);

        // Back-to-back reads 0000 / 0001, each accepted one clock late.
        lo(8'h00, 1'b1);
        check("wr_req_one", {15'd0, mem_if.mem_req}, 16'h0000);
        check("wr_dbin",    {8'd0, cpu_db_in},       16'h005A);
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 8'h11;
        hi(8'h00, 8'h00, 8'h00);
        check("b2b_a_req",  {15'd0, mem_if.mem_req}, 16'h0001);
        check("b2b_a_addr", mem_if.mem_addr,         16'h0000);
        lo(8'h01, 1'b1);
        check("b2b_a_stall", mem_if.mem_addr, 16'h0000);
        mem_if.mem_ready = 1'b1;
        hi(8'h00, 8'h00, 8'h00);
        check("b2b_a_dbin", {8'd0, cpu_db_in},       16'h0011);
        check("b2b_b_addr", mem_if.mem_addr,         16'h0001);
        check("b2b_b_req",  {15'd0, mem_if.mem_req}, 16'h0001);
        check("b2b_ovr",    {15'd0, overrun},        16'h0000);

        // B accepted one clock late, request to 16'h2000 loaded back-to-back.
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 8'h22;
        lo(8'h00, 1'b1);
        mem_if.mem_ready = 1'b1;
        hi(8'h20, 8'h00, 8'h00);
        check("b2b_b_dbin", {8'd0, cpu_db_in}, 16'h0022);
        check("ovr_addr0",  mem_if.mem_addr,   16'h2000);
        check("ovr_pre",    {15'd0, overrun},  16'h0000);

        // Stall 3 clocks: bus cycle 16'h3456 is dropped.
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 8'h33;
        lo(8'h56, 1'b1);
        check("ovr_addr1", mem_if.mem_addr, 16'h2000);
        hi(8'h34, 8'h00, 8'h00);
        check("ovr_set",   {15'd0, overrun},        16'h0001);
        check("ovr_addr2", mem_if.mem_addr,         16'h2000);
        check("ovr_req",   {15'd0, mem_if.mem_req}, 16'h0001);
        lo(8'h78, 1'b1);
        check("ovr_addr3", mem_if.mem_addr,  16'h2000);
        check("ovr_dbin",  {8'd0, cpu_db_in}, 16'h0022);

        // 16'h2000 accepted; next read carries a write-direction oe.
        mem_if.mem_ready = 1'b1;
        hi(8'h9A, 8'h00, 8'hFF);
        check("perr_dbin", {8'd0, cpu_db_in},     16'h0033);
        check("perr_addr", mem_if.mem_addr,       16'h9A78);
        check("perr_set",  {15'd0, protocol_err}, 16'h0001);
        check("ovr_stick", {15'd0, overrun},      16'h0001);
        mem_if.mem_rdata = 8'h44;
        lo(8'h00, 1'b1);
        check("perr_stick", {15'd0, protocol_err},   16'h0001);
        check("e_dbin",     {8'd0, cpu_db_in},       16'h0044);
        check("e_req_done", {15'd0, mem_if.mem_req}, 16'h0000);
        hi(8'h00, 8'h00, 8'h00);
        check("f_req", {15'd0, mem_if.mem_req}, 16'h0001);

        // Asynchronous reset while a request is pending.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_req",   {15'd0, mem_if.mem_req},  16'h0000);
        check("arst_addr",  mem_if.mem_addr,          16'h0000);
        check("arst_wdata", {8'd0, mem_if.mem_wdata}, 16'h0000);
        check("arst_dbin",  {8'd0, cpu_db_in},        16'h00EA);
        check("arst_phase", {15'd0, phase},           16'h0001);
        check("arst_ovr",   {15'd0, overrun},         16'h0000);
        check("arst_perr",  {15'd0, protocol_err},    16'h0000);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_phase", {15'd0, phase},          16'h0001);
        check("rel_dbin",  {8'd0, cpu_db_in},       16'h00EA);
        check("rel_req",   {15'd0, mem_if.mem_req}, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
